// File: rtl/matrix_sched_pkg.sv
// matrix_sched_pkg
//   Shared definitions for the matrix multiplier scheduler:
//   - sched_state_t : scheduler FSM state encoding
//   - DEF_*         : default engine/scheduler configuration
//   - M1_SIZE, M2_SIZE, RES_SIZE : flattened matrix widths for the defaults
//   - m1_size/m2_size/res_size   : the same derivations for any parameter set
//   - idx_width     : requester index width, clog2(NUM_REQ), at least 1
package matrix_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } sched_state_t;

  localparam int unsigned DEF_NUM_REQ             = 4;
  localparam int unsigned DEF_FIRST_MATRIX_HEIGHT = 2;
  localparam int unsigned DEF_BOTH_MATRIX_W_H     = 2;
  localparam int unsigned DEF_SECOND_MATRIX_WIDTH = 2;
  localparam int unsigned DEF_DATA_WIDTH          = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES      = 255;

  function automatic int unsigned m1_size(input int unsigned h, input int unsigned wh,
                                          input int unsigned dw);
    return h * wh * dw;
  endfunction

  function automatic int unsigned m2_size(input int unsigned w, input int unsigned wh,
                                          input int unsigned dw);
    return w * wh * dw;
  endfunction

  function automatic int unsigned res_size(input int unsigned h, input int unsigned w,
                                           input int unsigned dw);
    return h * w * dw;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned M1_SIZE  = m1_size(DEF_FIRST_MATRIX_HEIGHT, DEF_BOTH_MATRIX_W_H,
                                             DEF_DATA_WIDTH);
  localparam int unsigned M2_SIZE  = m2_size(DEF_SECOND_MATRIX_WIDTH, DEF_BOTH_MATRIX_W_H,
                                             DEF_DATA_WIDTH);
  localparam int unsigned RES_SIZE = res_size(DEF_FIRST_MATRIX_HEIGHT, DEF_SECOND_MATRIX_WIDTH,
                                              DEF_DATA_WIDTH);

endpackage

// File: rtl/matrix_mult_scheduler_if.sv
// matrix_mult_scheduler_if
//   Bundles the requester-side and engine-side signals of the scheduler.
//   Requester side : i_req, i_matrix_1, i_matrix_2 (in); o_grant, o_done,
//                    o_error, o_result, o_busy (out)
//   Engine side    : o_mm_calc, o_mm_rst_n, o_mm_matrix_1, o_mm_matrix_2 (out);
//                    i_mm_result, i_mm_ready (in)
//   Modports: slave  = scheduler view
//             master = requesters + engine view
interface matrix_mult_scheduler_if
  import matrix_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ             = DEF_NUM_REQ,
  parameter int unsigned FIRST_MATRIX_HEIGHT = DEF_FIRST_MATRIX_HEIGHT,
  parameter int unsigned BOTH_MATRIX_W_H     = DEF_BOTH_MATRIX_W_H,
  parameter int unsigned SECOND_MATRIX_WIDTH = DEF_SECOND_MATRIX_WIDTH,
  parameter int unsigned DATA_WIDTH          = DEF_DATA_WIDTH
);
  localparam int unsigned M1 = m1_size(FIRST_MATRIX_HEIGHT, BOTH_MATRIX_W_H, DATA_WIDTH);
  localparam int unsigned M2 = m2_size(SECOND_MATRIX_WIDTH, BOTH_MATRIX_W_H, DATA_WIDTH);
  localparam int unsigned RS = res_size(FIRST_MATRIX_HEIGHT, SECOND_MATRIX_WIDTH, DATA_WIDTH);

  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ*M1-1:0] i_matrix_1;
  logic [NUM_REQ*M2-1:0] i_matrix_2;
  logic [NUM_REQ-1:0]    o_grant;
  logic [NUM_REQ-1:0]    o_done;
  logic                  o_error;
  logic [RS-1:0]         o_result;
  logic                  o_busy;
  logic                  o_mm_calc;
  logic                  o_mm_rst_n;
  logic [M1-1:0]         o_mm_matrix_1;
  logic [M2-1:0]         o_mm_matrix_2;
  logic [RS-1:0]         i_mm_result;
  logic                  i_mm_ready;

  modport slave (
    input  i_req, i_matrix_1, i_matrix_2, i_mm_result, i_mm_ready,
    output o_grant, o_done, o_error, o_result, o_busy,
           o_mm_calc, o_mm_rst_n, o_mm_matrix_1, o_mm_matrix_2
  );

  modport master (
    output i_req, i_matrix_1, i_matrix_2, i_mm_result, i_mm_ready,
    input  o_grant, o_done, o_error, o_result, o_busy,
           o_mm_calc, o_mm_rst_n, o_mm_matrix_1, o_mm_matrix_2
  );

endinterface

// File: rtl/matrix_mult_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first requester after `last`
//   (wrapping) whose request bit is set.
//   Ports: req   (in)  request vector
//          last  (in)  index of the previous winner
//          grant (out) one-hot winner
//          idx   (out) binary winner index
//          valid (out) any request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cidx;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    cidx  = '0;
    // Scan offsets 1..NUM_REQ so `last` itself is considered last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last) + off) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!valid && req[cidx]) begin
        valid       = 1'b1;
        idx         = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_mult_scheduler.sv
// matrix_mult_scheduler
//   Shares one matrix multiplier engine among NUM_REQ requesters. A round-robin
//   winner's operands are latched, the engine is cleared, launched with a
//   one-cycle calc pulse, and the result is returned with a one-cycle done.
//   Ports: clk   (in) clock, rising edge
//          i_rst (in) asynchronous active-high reset
//          bus   (slave modport of matrix_mult_scheduler_if): requester
//                request/operands/grant/done/result/busy and engine
//                calc/rst_n/operands/result/ready
//   Optional build macro MM_SCHED_TIMEOUT_EN: WAIT watchdog of TIMEOUT_CYCLES
//   cycles that completes the job with a zero result and o_error.
module matrix_mult_scheduler
  import matrix_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ             = DEF_NUM_REQ,
  parameter int unsigned FIRST_MATRIX_HEIGHT = DEF_FIRST_MATRIX_HEIGHT,
  parameter int unsigned BOTH_MATRIX_W_H     = DEF_BOTH_MATRIX_W_H,
  parameter int unsigned SECOND_MATRIX_WIDTH = DEF_SECOND_MATRIX_WIDTH,
  parameter int unsigned DATA_WIDTH          = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    i_rst,
  matrix_mult_scheduler_if.slave  bus
);

  localparam int unsigned M1    = m1_size(FIRST_MATRIX_HEIGHT, BOTH_MATRIX_W_H, DATA_WIDTH);
  localparam int unsigned M2    = m2_size(SECOND_MATRIX_WIDTH, BOTH_MATRIX_W_H, DATA_WIDTH);
  localparam int unsigned RS    = res_size(FIRST_MATRIX_HEIGHT, SECOND_MATRIX_WIDTH, DATA_WIDTH);
  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("matrix_mult_scheduler: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  sched_state_t       state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   cur_idx;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [RS-1:0]      result_q;
  logic               busy_q;
  logic               calc_q;
  logic               mm_rst_n_q;
  logic [M1-1:0]      m1_q;
  logic [M2-1:0]      m2_q;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [M1-1:0]      sel_m1;
  logic [M2-1:0]      sel_m2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (bus.i_req),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_m1 = '0;
    sel_m2 = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (arb_idx == IDX_W'(r)) begin
        sel_m1 = bus.i_matrix_1[r*M1 +: M1];
        sel_m2 = bus.i_matrix_2[r*M2 +: M2];
      end
    end
  end

`ifdef MM_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      last       <= IDX_W'(NUM_REQ - 1);
      cur_idx    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      calc_q     <= 1'b0;
      mm_rst_n_q <= 1'b0;
      m1_q       <= '0;
      m2_q       <= '0;
`ifdef MM_SCHED_TIMEOUT_EN
      wd_cnt     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      calc_q  <= 1'b0;
`ifdef MM_SCHED_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          mm_rst_n_q <= 1'b1;
          if (arb_valid) begin
            cur_idx    <= arb_idx;
            last       <= arb_idx;
            grant_q    <= arb_grant;
            m1_q       <= sel_m1;
            m2_q       <= sel_m2;
            // Engine reset is driven low for the whole CLEAR cycle so a
            // ready left over from the previous job cannot be seen in WAIT.
            mm_rst_n_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          mm_rst_n_q <= 1'b1;
          calc_q     <= 1'b1;
          state      <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
`ifdef MM_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_mm_ready) begin
            result_q        <= bus.i_mm_result;
            done_q[cur_idx] <= 1'b1;
            state           <= ST_DONE;
          end
`ifdef MM_SCHED_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            result_q        <= '0;
            done_q[cur_idx] <= 1'b1;
            error_q         <= 1'b1;
            state           <= ST_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_grant       = grant_q;
  assign bus.o_done        = done_q;
  assign bus.o_result      = result_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_mm_calc     = calc_q;
  assign bus.o_mm_rst_n    = mm_rst_n_q;
  assign bus.o_mm_matrix_1 = m1_q;
  assign bus.o_mm_matrix_2 = m2_q;
`ifdef MM_SCHED_TIMEOUT_EN
  assign bus.o_error       = error_q;
`else
  assign bus.o_error       = 1'b0;
`endif

endmodule
